// File: rtl/lcd_bus_receiver.sv
// HD44780-style 8-bit bus receiver: snoops controller writes on the LCD bus,
// keeps a 2x16 shadow of the visible characters and flags protocol faults.
module lcd_bus_receiver #(
    parameter int unsigned T_E_MIN    = 20,
    parameter int unsigned T_BUSY_STD = 2000,
    parameter int unsigned T_BUSY_CLR = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       ready,
    output logic       display_on,
    output logic       cmd_strobe,
    output logic       data_strobe,
    output logic       frame_done,
    output logic       err_timing,
    output logic       err_pulse,
    output logic       err_rw
);

    localparam int unsigned BUSY_MAX = (T_BUSY_CLR > T_BUSY_STD) ? T_BUSY_CLR : T_BUSY_STD;
    localparam int unsigned BW       = $clog2(BUSY_MAX + 2);
    localparam int unsigned EW       = $clog2(T_E_MIN + 2);

    localparam logic [BW-1:0] BUSY_STD = BW'(T_BUSY_STD);
    localparam logic [BW-1:0] BUSY_CLR = BW'(T_BUSY_CLR);
    localparam logic [EW-1:0] E_MIN    = EW'(T_E_MIN);

    typedef enum logic [1:0] {
        S_UNINIT,
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        state_q, state_d;

    logic          e_q, rs_q, rw_q;
    logic [7:0]    data_q;
    logic [EW-1:0] e_cnt;
    logic          fall;

    logic          pend_valid, pend_short, pend_rs, pend_rw;
    logic [7:0]    pend_data;

    logic [BW-1:0] busy_cnt;
    logic          accept;
    logic          set_err_pulse, set_err_timing, set_err_rw;
    logic [BW-1:0] busy_load;

    logic [7:0]    buffer [32];
    logic [6:0]    ac, ac_step;
    logic          inc;
    logic          cgram_mode;
    logic          store_hit;
    logic [4:0]    store_idx;

    assign fall    = e_q & ~lcd_e;
    assign ready   = (state_q != S_UNINIT);
    assign rd_char = buffer[rd_addr];

    // Single register stage on the raw bus; the transfer uses the values held while E was high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q    <= 1'b0;
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
            data_q <= '0;
        end else begin
            e_q    <= lcd_e;
            rs_q   <= lcd_rs;
            rw_q   <= lcd_rw;
            data_q <= lcd_data;
        end
    end

    // E-high width counter, saturating at the minimum so only "too short" matters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_cnt <= '0;
        end else if (!lcd_e) begin
            e_cnt <= '0;
        end else if (e_cnt != E_MIN) begin
            e_cnt <= e_cnt + 1'b1;
        end
    end

    // Latch a detected transfer so all effects land two cycles after E drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_short <= 1'b0;
            pend_rs    <= 1'b0;
            pend_rw    <= 1'b0;
            pend_data  <= '0;
        end else begin
            pend_valid <= fall;
            pend_short <= (e_cnt < E_MIN);
            pend_rs    <= rs_q;
            pend_rw    <= rw_q;
            pend_data  <= data_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_UNINIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Transfer qualification and next-state logic; faults are checked before acceptance.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        set_err_pulse  = 1'b0;
        set_err_timing = 1'b0;
        set_err_rw     = 1'b0;
        if (pend_valid) begin
            if (pend_short) begin
                set_err_pulse = 1'b1;
            end else if (busy_cnt != '0) begin
                set_err_timing = 1'b1;
            end else if (pend_rw) begin
                set_err_rw = 1'b1;
            end else if (state_q != S_UNINIT ||
                         (!pend_rs && pend_data[7:5] == 3'b001 && pend_data[3])) begin
                accept = 1'b1;
            end
        end
        case (state_q)
            S_UNINIT: if (accept) state_d = S_BUSY;
            S_IDLE:   if (accept) state_d = S_BUSY;
            S_BUSY:   if (busy_cnt <= BW'(1)) state_d = S_IDLE;
            default:  state_d = S_UNINIT;
        endcase
    end

    // Busy window length: clear and return-home are the slow commands.
    always_comb begin
        busy_load = BUSY_STD;
        if (!pend_rs && pend_data[7:2] == 6'b000000 && pend_data[1:0] != 2'b00) begin
            busy_load = BUSY_CLR;
        end
    end

    // Busy countdown, reloaded by every accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (accept) begin
            busy_cnt <= busy_load;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end

    // DDRAM address to shadow index mapping and 2-line address counter stepping.
    always_comb begin
        store_hit = 1'b0;
        store_idx = '0;
        if (ac[6:4] == 3'b000) begin
            store_hit = 1'b1;
            store_idx = {1'b0, ac[3:0]};
        end else if (ac[6:4] == 3'b100) begin
            store_hit = 1'b1;
            store_idx = {1'b1, ac[3:0]};
        end
        if (inc) begin
            if (ac == 7'h27)      ac_step = 7'h40;
            else if (ac == 7'h67) ac_step = 7'h00;
            else                  ac_step = ac + 1'b1;
        end else begin
            if (ac == 7'h00)      ac_step = 7'h67;
            else if (ac == 7'h40) ac_step = 7'h27;
            else                  ac_step = ac - 1'b1;
        end
    end

    // Apply accepted transfers: shadow buffer, AC, mode bits, strobes and sticky errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                buffer[i] <= 8'h20;
            end
            ac          <= '0;
            inc         <= 1'b1;
            cgram_mode  <= 1'b0;
            display_on  <= 1'b0;
            cmd_strobe  <= 1'b0;
            data_strobe <= 1'b0;
            frame_done  <= 1'b0;
            err_timing  <= 1'b0;
            err_pulse   <= 1'b0;
            err_rw      <= 1'b0;
        end else begin
            cmd_strobe  <= 1'b0;
            data_strobe <= 1'b0;
            frame_done  <= 1'b0;
            if (set_err_pulse)  err_pulse  <= 1'b1;
            if (set_err_timing) err_timing <= 1'b1;
            if (set_err_rw)     err_rw     <= 1'b1;
            if (accept) begin
                if (pend_rs) begin
                    data_strobe <= 1'b1;
                    if (!cgram_mode && store_hit) begin
                        buffer[store_idx] <= pend_data;
                        frame_done        <= (store_idx == 5'd31);
                    end
                    ac <= ac_step;
                end else begin
                    cmd_strobe <= 1'b1;
                    casez (pend_data)
                        8'b1???????: begin
                            ac         <= pend_data[6:0];
                            cgram_mode <= 1'b0;
                        end
                        8'b01??????: cgram_mode <= 1'b1;
                        8'b001?????: ;
                        8'b0001????: ;
                        8'b00001???: display_on <= pend_data[2];
                        8'b000001??: inc <= pend_data[1];
                        8'b0000001?: ac <= '0;
                        8'b00000001: begin
                            for (int unsigned i = 0; i < 32; i++) begin
                                buffer[i] <= 8'h20;
                            end
                            ac  <= '0;
                            inc <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with shortened busy windows.
module tb_lcd_bus_receiver;

    localparam int unsigned GAP_STD = 220;
    localparam int unsigned GAP_CLR = 1020;

    logic       clk = 1'b0;
    logic       rst, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       ready, display_on, cmd_strobe, data_strobe, frame_done;
    logic       err_timing, err_pulse, err_rw;

    int unsigned tests_run = 0, tests_failed = 0;
    int unsigned n_cmd = 0, n_data = 0, n_frame = 0, frame_at = 0;
    logic        frame_with_data = 1'b0;
    int unsigned base_cmd, base_data, base_frame;
    logic [7:0]  exp_buf [32];
    string       s;

    lcd_bus_receiver #(
        .T_E_MIN(20),
        .T_BUSY_STD(200),
        .T_BUSY_CLR(1000)
    ) dut (
        .clk(clk), .rst(rst),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
        .rd_addr(rd_addr), .rd_char(rd_char),
        .ready(ready), .display_on(display_on),
        .cmd_strobe(cmd_strobe), .data_strobe(data_strobe), .frame_done(frame_done),
        .err_timing(err_timing), .err_pulse(err_pulse), .err_rw(err_rw)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_strobe) n_cmd++;
        if (data_strobe) n_data++;
        if (frame_done) begin
            n_frame++;
            frame_at        = n_data;
            frame_with_data = data_strobe;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d, input int unsigned hi);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_e    = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] d, input int unsigned gap);
        bus_xfer(1'b0, 1'b0, d, 25);
        idle(gap);
    endtask

    task automatic dat(input logic [7:0] d);
        bus_xfer(1'b1, 1'b0, d, 25);
        idle(GAP_STD);
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), 32'(rd_char), 32'(exp_buf[i]));
        end
    endtask

    task automatic blank_exp();
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    endtask

    initial begin
        rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);
        blank_exp();

        // reset state
        check("rst_ready", 32'(ready), 0);
        check("rst_disp", 32'(display_on), 0);
        check("rst_cmd_strobe", 32'(cmd_strobe), 0);
        check("rst_data_strobe", 32'(data_strobe), 0);
        check("rst_frame", 32'(frame_done), 0);
        check("rst_err_timing", 32'(err_timing), 0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_err_rw", 32'(err_rw), 0);
        check_buf("rst_buf");

        // before function set: data and other commands silently ignored
        base_cmd = n_cmd; base_data = n_data;
        bus_xfer(1'b1, 1'b0, 8'h41, 25); idle(20);
        cmd(8'h0C, 20);
        check("pre_ready", 32'(ready), 0);
        check("pre_disp", 32'(display_on), 0);
        check("pre_cmd_cnt", n_cmd - base_cmd, 0);
        check("pre_data_cnt", n_data - base_data, 0);
        check("pre_err_pulse", 32'(err_pulse), 0);
        check("pre_err_timing", 32'(err_timing), 0);
        rd_addr = 5'd0; #1;
        check("pre_buf0", 32'(rd_char), 32'h20);

        // init sequence; strobe latency observed on the function set
        bus_xfer(1'b0, 1'b0, 8'h38, 51);
        @(negedge clk);
        check("lat1_strobe", 32'(cmd_strobe), 0);
        check("lat1_ready", 32'(ready), 0);
        @(negedge clk);
        check("lat2_strobe", 32'(cmd_strobe), 1);
        check("lat2_ready", 32'(ready), 1);
        @(negedge clk);
        check("lat3_strobe", 32'(cmd_strobe), 0);
        idle(GAP_STD);
        bus_xfer(1'b0, 1'b0, 8'h0C, 51); idle(GAP_STD);
        bus_xfer(1'b0, 1'b0, 8'h01, 51); idle(GAP_CLR);
        bus_xfer(1'b0, 1'b0, 8'h06, 51); idle(GAP_STD);
        check("init_ready", 32'(ready), 1);
        check("init_disp", 32'(display_on), 1);
        check("init_cmd_cnt", n_cmd - base_cmd, 4);
        check("init_err_timing", 32'(err_timing), 0);
        check("init_err_pulse", 32'(err_pulse), 0);
        check("init_err_rw", 32'(err_rw), 0);

        // text on both lines
        cmd(8'h80, GAP_STD);
        s = "LOAD";
        for (int i = 0; i < 4; i++) dat(s[i]);
        cmd(8'hC0, GAP_STD);
        s = "+00042";
        for (int i = 0; i < 6; i++) dat(s[i]);
        exp_buf[0] = "L"; exp_buf[1] = "O"; exp_buf[2] = "A"; exp_buf[3] = "D";
        exp_buf[16] = "+"; exp_buf[17] = "0"; exp_buf[18] = "0";
        exp_buf[19] = "0"; exp_buf[20] = "4"; exp_buf[21] = "2";
        check_buf("text");

        // AC 0x27 is off-screen; increment wraps to 0x40 (index 16)
        cmd(8'hA7, GAP_STD);
        dat("X");
        dat("Y");
        exp_buf[16] = "Y";
        check_buf("wrap_inc");

        // display control
        cmd(8'h08, GAP_STD);
        check("disp_off", 32'(display_on), 0);
        cmd(8'h0C, GAP_STD);
        check("disp_on", 32'(display_on), 1);

        // clear then full frame
        cmd(8'h01, GAP_CLR);
        blank_exp();
        check_buf("clear");
        base_data = n_data; base_frame = n_frame;
        cmd(8'h80, GAP_STD);
        for (int i = 0; i < 16; i++) dat(8'(8'h61 + i));
        cmd(8'hC0, GAP_STD);
        for (int i = 0; i < 15; i++) dat(8'(8'h41 + i));
        check("frame_early", n_frame - base_frame, 0);
        dat(8'h50);
        check("frame_count", n_frame - base_frame, 1);
        check("frame_at_32", frame_at - base_data, 32);
        check("frame_with_strobe", 32'(frame_with_data), 1);
        for (int i = 0; i < 16; i++) exp_buf[i] = 8'(8'h61 + i);
        for (int i = 0; i < 16; i++) exp_buf[16 + i] = 8'(8'h41 + i);
        check_buf("frame");

        // decrement: 0x41 -> 0x40 -> 0x27 (not stored)
        cmd(8'h04, GAP_STD);
        cmd(8'hC1, GAP_STD);
        dat("Q");
        dat("R");
        dat("S");
        cmd(8'h06, GAP_STD);
        exp_buf[17] = "Q"; exp_buf[16] = "R";
        check_buf("wrap_dec");

        // write inside the busy window is discarded
        cmd(8'h80, GAP_STD);
        base_data = n_data;
        bus_xfer(1'b1, 1'b0, "1", 25);
        idle(100);
        bus_xfer(1'b1, 1'b0, "2", 25);
        idle(GAP_STD);
        check("busy_err_timing", 32'(err_timing), 1);
        check("busy_err_pulse", 32'(err_pulse), 0);
        check("busy_data_cnt", n_data - base_data, 1);
        exp_buf[0] = "1";

        // short E pulse rejected; exactly T_E_MIN accepted
        bus_xfer(1'b1, 1'b0, "3", 19); idle(GAP_STD);
        check("short_err_pulse", 32'(err_pulse), 1);
        check("short_data_cnt", n_data - base_data, 1);
        bus_xfer(1'b1, 1'b0, "4", 20); idle(GAP_STD);
        check("min_data_cnt", n_data - base_data, 2);
        exp_buf[1] = "4";

        // read cycle rejected
        base_cmd = n_cmd;
        bus_xfer(1'b0, 1'b1, 8'h01, 25); idle(GAP_STD);
        check("rw_err", 32'(err_rw), 1);
        check("rw_cmd_cnt", n_cmd - base_cmd, 0);
        check_buf("faults");
        cmd(8'h0C, GAP_STD);
        check("sticky_timing", 32'(err_timing), 1);
        check("sticky_pulse", 32'(err_pulse), 1);
        check("sticky_rw", 32'(err_rw), 1);

        // reset in the middle of an E-high phase
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h38; lcd_e = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ready), 0);
        check("mid_rst_disp", 32'(display_on), 0);
        check("mid_rst_err_timing", 32'(err_timing), 0);
        check("mid_rst_err_pulse", 32'(err_pulse), 0);
        check("mid_rst_err_rw", 32'(err_rw), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lcd_e = 1'b0;
        base_cmd = n_cmd;
        idle(5);
        blank_exp();
        check("post_rst_err_pulse", 32'(err_pulse), 0);
        check("post_rst_ready", 32'(ready), 0);
        check_buf("post_rst");
        bus_xfer(1'b0, 1'b0, 8'h38, 25);
        idle(3);
        check("post_rst_fs_ready", 32'(ready), 1);
        check("post_rst_fs_disp", 32'(display_on), 0);
        check("post_rst_cmd_cnt", n_cmd - base_cmd, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
